inst_fetch_queue: RTL and testbench

Fetch stage that sits directly upstream of the IF/ID pipeline register. It drives a PC, issues single-outstanding requests to a variable-latency instruction memory, and buffers returned words with their PC+4 in a small FIFO. It presents one instruction per cycle to IF/ID, honours load-use stalls, and flushes on branch/jump redirects.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/inst_fetch_queue.sv | 126 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: FSM states and queue entry payload.
package fetch_pkg;

  localparam int unsigned ENTRY_AW = 32;
  localparam int unsigned INST_W   = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [ENTRY_AW-1:0] pc_plus4;
    logic [INST_W-1:0]   inst;
  } fetch_entry_t;

  // Value presented on the head when the queue is empty.
  localparam fetch_entry_t EMPTY_ENTRY = '{pc_plus4: '0, inst: NOP_INST};

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched words with flush and a registered head entry.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic                   head_valid_o,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             head_valid_q, head_valid_d;
  fetch_entry_t     head_q, head_d;
  logic             push_en, pop_en;

  // Next pointers, occupancy and head; a word pushed into the slot that becomes head bypasses storage.
  always_comb begin
    pop_en       = pop_i && (count_q != '0);
    push_en      = push_i && ((count_q != CNT_W'(DEPTH)) || pop_en);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_valid_d = 1'b0;
    head_d       = EMPTY_ENTRY;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
      if (count_d != '0) begin
        head_valid_d = 1'b1;
        head_d       = (push_en && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    if (push_en && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= EMPTY_ENTRY;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;
  assign count_o      = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: single-outstanding instruction memory requests feeding a small queue toward IF/ID.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_data_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_plus4_o
);

  localparam int unsigned       CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              mem_req_q;
  logic              push, pop, flush;
  logic [CNT_W-1:0]  count, count_after;
  logic              room;
  logic              head_valid;
  fetch_entry_t      head, push_data;
  logic [ADDR_W-1:0] redirect_target;
  logic [1:0]        unused_pc_lsb;

  // Redirect targets are word aligned; the low address bits carry no meaning.
  assign redirect_target = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign unused_pc_lsb   = redirect_pc_i[1:0];

  assign push_data = '{pc_plus4: ENTRY_AW'(fetch_pc_q + PC_STEP), inst: mem_data_i};

  // Next-state, fetch PC and queue control; redirect overrides every other event.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    count_after = count;
    room        = 1'b0;
    if (redirect_i) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_target;
      case (state_q)
        REQ, DROP: begin
          // An ack arriving with the redirect retires the stale request immediately.
          if (mem_ack_i) state_d = start_i ? REQ : IDLE;
          else           state_d = DROP;
        end
        default: state_d = state_q;
      endcase
    end else begin
      pop         = head_valid && !stall_i;
      push        = (state_q == REQ) && mem_ack_i;
      count_after = count + CNT_W'(push) - CNT_W'(pop);
      room        = count_after < CNT_W'(DEPTH);
      case (state_q)
        IDLE: begin
          if (start_i) state_d = room ? REQ : HOLD;
        end
        REQ: begin
          if (mem_ack_i) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            if (!start_i)  state_d = IDLE;
            else if (room) state_d = REQ;
            else           state_d = HOLD;
          end
        end
        HOLD: begin
          if (!start_i)  state_d = IDLE;
          else if (room) state_d = REQ;
        end
        DROP: begin
          if (mem_ack_i) state_d = start_i ? REQ : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, fetch PC and request-valid registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= (state_d == REQ);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .flush_i      (flush),
    .head_valid_o (head_valid),
    .head_o       (head),
    .count_o      (count)
  );

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = fetch_pc_q;
  assign valid_o    = head_valid;
  assign inst_o     = head.inst;
  assign pc_plus4_o = ADDR_W'(head.pc_plus4);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a variable-latency instruction memory responder.
`timescale 1ns/1ps
module tb_inst_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, start_i, stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o, mem_ack_i, valid_o;
  logic [31:0] mem_addr_o, mem_data_i, inst_o, pc_plus4_o;

  int n_chk  = 0;
  int n_pass = 0;

  int unsigned lat      = 1;
  bit          rsp_busy = 1'b0;
  int unsigned rsp_cnt  = 0;
  logic [31:0] rsp_addr = '0;
  int          hold_err = 0;

  inst_fetch_queue #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .inst_o(inst_o), .pc_plus4_o(pc_plus4_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Memory: latch a request, ack it 'lat' cycles later even if the fetch stage stops requesting.
  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (rsp_busy) begin
        if (mem_req_o && (mem_addr_o != rsp_addr)) hold_err++;
        rsp_cnt++;
        if (rsp_cnt >= lat) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem_word(rsp_addr);
          rsp_busy   = 1'b0;
        end
      end else if (mem_req_o) begin
        rsp_busy = 1'b1;
        rsp_cnt  = 0;
        rsp_addr = mem_addr_o;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    step(); step();
    rst_i = 1'b0;
    for (int k = 0; k < 10 && (rsp_busy || mem_ack_i); k++) step();
  endtask

  // Consume n queue entries (stall must be low) and check their order from first_pc4.
  task automatic collect(input int n, input logic [31:0] first_pc4, input string tag);
    int got = 0;
    logic [31:0] exp_pc4;
    for (int cyc = 0; cyc < 80 && got < n; cyc++) begin
      if (valid_o) begin
        exp_pc4 = first_pc4 + 32'(4 * got);
        chk($sformatf("%s.pc4[%0d]", tag, got), pc_plus4_o, exp_pc4);
        chk($sformatf("%s.inst[%0d]", tag, got), inst_o, mem_word(exp_pc4 - 32'd4));
        got++;
      end
      if (got < n) step();
    end
    if (got < n) fail_now({tag, ".collect"});
  endtask

  typedef struct {
    logic        start;
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vec [10];

  initial begin
    bit found;
    bit saw_valid;

    // Streaming at latency 1, then start dropped while a request is outstanding.
    vec[0] = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0,         32'h00};
    vec[1] = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0,         32'h00};
    vec[2] = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'hC0DE_0000, 32'h04};
    vec[3] = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0,         32'h00};
    vec[4] = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'hC0DE_0004, 32'h08};
    vec[5] = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b0, 32'h0,         32'h00};
    vec[6] = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'hC0DE_0008, 32'h0C};
    vec[7] = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b0, 32'h0,         32'h00};
    vec[8] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'hC0DE_000C, 32'h10};
    vec[9] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0,         32'h00};

    do_reset();
    lat = 1;
    chk("rst.req",   32'(mem_req_o), 32'h0);
    chk("rst.addr",  mem_addr_o,     32'h0);
    chk("rst.valid", 32'(valid_o),   32'h0);
    chk("rst.inst",  inst_o,         32'h0);
    chk("rst.pc4",   pc_plus4_o,     32'h0);

    for (int i = 0; i < 10; i++) begin
      start_i = vec[i].start;
      stall_i = vec[i].stall;
      step();
      chk($sformatf("v%0d.req", i),   32'(mem_req_o), 32'(vec[i].exp_req));
      chk($sformatf("v%0d.addr", i),  mem_addr_o,     vec[i].exp_addr);
      chk($sformatf("v%0d.valid", i), 32'(valid_o),   32'(vec[i].exp_valid));
      chk($sformatf("v%0d.inst", i),  inst_o,         vec[i].exp_inst);
      chk($sformatf("v%0d.pc4", i),   pc_plus4_o,     vec[i].exp_pc4);
    end

    // Long stall fills the queue and parks in HOLD; release drains in order.
    do_reset();
    lat = 1; start_i = 1'b1; stall_i = 1'b1;
    repeat (10) step();
    chk("stall.req",   32'(mem_req_o),        32'h0);
    chk("stall.state", 32'(dut.state_q),      32'(HOLD));
    chk("stall.count", 32'(dut.u_fifo.count_q), 32'd4);
    chk("stall.valid", 32'(valid_o),          32'h1);
    chk("stall.pc4",   pc_plus4_o,            32'h4);
    stall_i = 1'b0;
    collect(8, 32'h4, "stall");

    // Redirect one cycle into a latency-3 request: stale word dropped.
    do_reset();
    lat = 3; start_i = 1'b1; stall_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (mem_req_o && mem_addr_o == 32'h8) begin found = 1'b1; break; end
    end
    if (!found) fail_now("drop.wait_req8");
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    step();
    redirect_i = 1'b0;
    chk("drop.req",   32'(mem_req_o),   32'h0);
    chk("drop.state", 32'(dut.state_q), 32'(DROP));
    chk("drop.valid", 32'(valid_o),     32'h0);
    found = 1'b0; saw_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (valid_o) saw_valid = 1'b1;
      if (mem_req_o) begin found = 1'b1; break; end
    end
    if (!found) fail_now("drop.wait_refetch");
    chk("drop.no_stale", 32'(saw_valid), 32'h0);
    chk("drop.addr",     mem_addr_o,     32'h100);
    collect(2, 32'h104, "drop");

    // Redirect coinciding with an ack (misaligned target), with a stalled entry queued.
    do_reset();
    lat = 1; start_i = 1'b1; stall_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (mem_ack_i && mem_addr_o == 32'h4) begin found = 1'b1; break; end
    end
    if (!found) fail_now("rdack.wait_ack");
    redirect_i = 1'b1; redirect_pc_i = 32'h43;
    @(posedge clk); #1;
    redirect_i = 1'b0; stall_i = 1'b0;
    chk("rdack.valid", 32'(valid_o),            32'h0);
    chk("rdack.count", 32'(dut.u_fifo.count_q), 32'h0);
    chk("rdack.req",   32'(mem_req_o),          32'h1);
    chk("rdack.addr",  mem_addr_o,              32'h40);
    collect(2, 32'h44, "rdack");

    // Push and pop in the same cycle at two entries.
    do_reset();
    lat = 1; start_i = 1'b1; stall_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (mem_ack_i && mem_addr_o == 32'h8) begin found = 1'b1; break; end
    end
    if (!found) fail_now("pushpop.wait_ack");
    stall_i = 1'b0;
    @(posedge clk); #1;
    stall_i = 1'b1;
    chk("pushpop.count", 32'(dut.u_fifo.count_q), 32'd2);
    chk("pushpop.valid", 32'(valid_o),            32'h1);
    chk("pushpop.pc4",   pc_plus4_o,              32'h8);
    chk("pushpop.inst",  inst_o,                  32'hC0DE_0004);
    stall_i = 1'b0;
    collect(3, 32'h8, "pushpop");

    // Reset during a latency-3 request; the late ack must not push.
    do_reset();
    lat = 3; start_i = 1'b1; stall_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (mem_req_o && mem_addr_o == 32'h20) begin found = 1'b1; break; end
    end
    if (!found) fail_now("midrst.wait_req20");
    step();
    rst_i = 1'b1;
    step();
    chk("midrst.req",   32'(mem_req_o),   32'h0);
    chk("midrst.addr",  mem_addr_o,       32'h0);
    chk("midrst.valid", 32'(valid_o),     32'h0);
    chk("midrst.inst",  inst_o,           32'h0);
    chk("midrst.pc4",   pc_plus4_o,       32'h0);
    chk("midrst.state", 32'(dut.state_q), 32'(IDLE));
    rst_i = 1'b0; start_i = 1'b0;
    saw_valid = 1'b0;
    repeat (6) begin
      step();
      if (valid_o) saw_valid = 1'b1;
    end
    chk("midrst.no_push", 32'(saw_valid),            32'h0);
    chk("midrst.count",   32'(dut.u_fifo.count_q),   32'h0);
    start_i = 1'b1;
    step();
    chk("midrst.req2",  32'(mem_req_o), 32'h1);
    chk("midrst.addr2", mem_addr_o,     32'h0);
    collect(1, 32'h4, "midrst");

    // Redirect while idle to the top word; PC+4 wraps to zero.
    do_reset();
    lat = 1; start_i = 1'b0; stall_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    chk("wrap.req",   32'(mem_req_o), 32'h0);
    chk("wrap.addr",  mem_addr_o,     32'hFFFF_FFFC);
    chk("wrap.valid", 32'(valid_o),   32'h0);
    start_i = 1'b1;
    collect(2, 32'h0, "wrap");

    chk("req_addr_stable", 32'(hold_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
